// File: rtl/display_scan_controller_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_controller_pkg
// Shared definitions for the multiplexed 4-digit display scanner: the scan FSM
// state type, the decoder "all segments off" code, the digit count and a
// helper that sizes counters.
// -----------------------------------------------------------------------------
package display_scan_controller_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,   // anti-ghosting guard slot, digit forced dark
    S_SHOW  = 1'b1    // digit lit with its snapshot value
  } scan_state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         NUM_DIGITS = 4;

  // Bits needed to count 0..n-1; a 1-bit counter is kept even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : display_scan_controller_pkg

// File: rtl/display_scan_controller_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running counter 0..TICK_DIV-1 that produces a one-cycle scan tick in
// the cycle where the count reaches TICK_DIV-1.
//
// Parameters:
//   TICK_DIV : clock cycles per tick (>= 1; 1 gives a tick every cycle)
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   o_tick : tick pulse (combinational decode of the count register)
// -----------------------------------------------------------------------------
module tick_prescaler
  import display_scan_controller_pkg::*;
#(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = cnt_width(TICK_DIV);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == CW'(TICK_DIV - 1));

  // NOTE: asynchronous reset in the sensitivity list, and <= for every
  // register so all state updates see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule : tick_prescaler

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexes four BCD digits onto one decoder. Each digit slot is one
// blank tick (anti-ghosting guard) followed by SHOW_TICKS lit ticks. The digit
// values and blink mask are snapshotted at the start of every frame so a
// frame never shows a mix of old and new data.
//
// Build option: define SCAN_BLINK_EN to enable per-digit blinking. Without it
// blink_mask is accepted but has no effect and no blink counter is built.
//
// Parameters:
//   TICK_DIV    : clock cycles per scan tick (>= 1)
//   SHOW_TICKS  : ticks each digit is lit per slot (>= 1)
//   BLINK_TICKS : ticks per blink half-period (>= 1)
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   d0..d3      : BCD digit values, d0 leftmost
//   blink_mask  : bit i requests digit i to blink
//   digit_sel   : registered digit index for the decoder enable
//   digit_val   : registered decoder value, 4'hF = all segments off
//   blank       : registered, high while the current digit is dark
//   frame_start : registered one-cycle pulse at the start of each frame
// -----------------------------------------------------------------------------
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int TICK_DIV    = 25000,
  parameter int SHOW_TICKS  = 3,
  parameter int BLINK_TICKS = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] blink_mask,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_val,
  output logic       blank,
  output logic       frame_start
);

  localparam int SW = cnt_width(SHOW_TICKS);

  logic w_tick;

  scan_state_e                 r_state,       w_state_next;
  logic [1:0]                  r_digit_sel,   w_sel_next;
  logic [SW-1:0]               r_slot_cnt,    w_slot_next;
  logic [NUM_DIGITS-1:0][3:0]  r_snap,        w_snap_next;
  logic [NUM_DIGITS-1:0]       r_snap_mask,   w_mask_next;
  logic [3:0]                  r_digit_val,   w_val_next;
  logic                        r_blank,       w_blank_next;
  logic                        r_frame_start, w_fs_next;
  logic                        w_blink_phase_next;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

`ifdef SCAN_BLINK_EN
  localparam int BW = cnt_width(BLINK_TICKS);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          w_blink_wrap;

  // Blink runs on raw ticks, independent of slot and frame boundaries.
  assign w_blink_wrap       = w_tick && (r_blink_cnt == BW'(BLINK_TICKS - 1));
  assign w_blink_phase_next = r_blink_phase ^ w_blink_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_tick) begin
      r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
      r_blink_phase <= w_blink_phase_next;
    end
  end
`else
  assign w_blink_phase_next = 1'b0;
`endif

  // Next-state and next-output logic. Outputs are derived from the next
  // state so the registered outputs change on the same edge as the FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_sel_next   = r_digit_sel;
    w_slot_next  = r_slot_cnt;
    w_snap_next  = r_snap;
    w_mask_next  = r_snap_mask;
    w_fs_next    = 1'b0;

    if (w_tick) begin
      case (r_state)
        S_BLANK: begin
          w_state_next = S_SHOW;
          w_slot_next  = '0;
          // Entering digit 0's show slot starts a frame: capture inputs.
          if (r_digit_sel == 2'd0) begin
            w_snap_next = {d3, d2, d1, d0};
            w_mask_next = blink_mask;
            w_fs_next   = 1'b1;
          end
        end
        S_SHOW: begin
          if (r_slot_cnt == SW'(SHOW_TICKS - 1)) begin
            w_state_next = S_BLANK;
            w_sel_next   = r_digit_sel + 2'd1;
            w_slot_next  = '0;
          end else begin
            w_slot_next  = r_slot_cnt + SW'(1);
          end
        end
        default: w_state_next = S_BLANK;
      endcase
    end

    // Values A..F pass through untouched; the decoder blanks them itself.
    w_blank_next = (w_state_next == S_BLANK) ||
                   (w_mask_next[w_sel_next] && w_blink_phase_next);
    w_val_next   = w_blank_next ? BLANK_CODE : w_snap_next[w_sel_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BLANK;
      r_digit_sel   <= 2'd0;
      r_slot_cnt    <= '0;
      // NOTE: the snapshot is a small register bank, not RAM, and is reset so
      // the display is dark and deterministic until the first frame.
      r_snap        <= {NUM_DIGITS{BLANK_CODE}};
      r_snap_mask   <= '0;
      r_digit_val   <= BLANK_CODE;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_digit_sel   <= w_sel_next;
      r_slot_cnt    <= w_slot_next;
      r_snap        <= w_snap_next;
      r_snap_mask   <= w_mask_next;
      r_digit_val   <= w_val_next;
      r_blank       <= w_blank_next;
      r_frame_start <= w_fs_next;
    end
  end

  assign digit_sel   = r_digit_sel;
  assign digit_val   = r_digit_val;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

endmodule : display_scan_controller

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000, meaning the clock cycles per scan tick (minimum 1).
REQ-002 SHALL have parameter SHOW_TICKS, default 3, meaning the ticks each digit is lit per slot (minimum 1).
REQ-003 SHALL have parameter BLINK_TICKS, default 2000, meaning the ticks per blink half-period (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 SHALL have ports d0, d1, d2, d3, input, 4 bits each, BCD digit values with d0 as the leftmost digit.
REQ-007 SHALL have port blink_mask, input, 4 bits, where bit i requests that digit i blink.
REQ-008 SHALL have port digit_sel, output, 2 bits, the digit index that drives the decoder enable.
REQ-009 SHALL have port digit_val, output, 4 bits, the value sent to the decoder; 4'hF means all segments off.
REQ-010 SHALL have port blank, output, 1 bit, high while the current digit is forced dark.
REQ-011 SHALL have port frame_start, output, 1 bit, a one-cycle pulse at the start of each scan frame.

Function
REQ-012 SHALL run a prescaler counting 0..TICK_DIV-1 and wrapping to 0; the internal tick is high in the cycle where the count equals TICK_DIV-1.
REQ-013 SHALL implement a two-state FSM, S_BLANK and S_SHOW, whose transitions occur only on tick.
REQ-014 SHALL, in S_BLANK, stay for 1 tick then go to S_SHOW on the same digit, forming the anti-ghosting guard.
REQ-015 SHALL, in S_SHOW, count SHOW_TICKS ticks then go to S_BLANK with digit_sel+1, wrapping 3->0.
REQ-016 SHALL give a frame period of exactly 4*(1+SHOW_TICKS)*TICK_DIV cycles.
REQ-017 SHALL, on the tick that moves S_BLANK to S_SHOW with digit_sel=0, snapshot d0..d3 and blink_mask, and assert frame_start for that one cycle.
REQ-018 SHALL keep the snapshot constant for the rest of the frame, so input changes mid-frame never appear until the next frame.
REQ-019 SHALL, in S_BLANK, drive blank=1 and digit_val=4'hF.
REQ-020 SHALL, in S_SHOW, drive digit_val equal to the snapshot value of digit_sel and blank=0, except as REQ-022 states.
REQ-021 SHALL register all outputs, updating them on the same edge as the FSM state.
REQ-022 SHALL, with blink compiled in, force blank=1 and digit_val=4'hF in S_SHOW while blink_phase=1 and the snapshot mask bit for digit_sel is 1.
REQ-023 SHALL toggle blink_phase every BLINK_TICKS ticks, independent of FSM state and frame boundaries.
REQ-024 SHALL pass snapshot values of 4'hA..4'hF through unchanged, leaving the decoder to blank them.

Reset
REQ-025 SHALL, while rst_n=0, hold prescaler=0, state=S_BLANK, digit_sel=0, slot count=0, blink count=0, blink_phase=0, snapshot digits=4'hF, snapshot mask=0, digit_val=4'hF, blank=1 and frame_start=0.
REQ-026 SHALL, on reset mid-frame, abandon the frame and restart at REQ-025 values with no partial pulse.

Configuration
REQ-027 SHALL, with SCAN_BLINK_EN defined, implement REQ-022 and REQ-023.
REQ-028 SHALL, without SCAN_BLINK_EN, keep the blink_mask port but ignore it, tie blink_phase to 0 and omit the blink counter.

Structure
REQ-029 SHALL take the FSM state enum, the 4'hF blank code and the digit count constant from the shared display package.
REQ-030 SHALL place the prescaler in a sub-module named tick_prescaler, parameterised by TICK_DIV and producing a tick pulse.

Verification (TICK_DIV=4, SHOW_TICKS=3, BLINK_TICKS=2)
REQ-031 SHALL cover: release reset -> first tick at cycle 4, then frame_start=1 for one cycle and digit_val=d0; digit_sel sequence 0,0,1,1,2,2,3,3 across the blank/show slots; frame period 64 cycles.
REQ-032 SHALL cover: d1 changed from 5 to 7 while digit_sel=2 -> digit 1 shows 5 until the next frame, then 7.
REQ-033 SHALL cover: blink_mask=4'b0010 with macro defined -> digit 1 shows 4'hF with blank=1 when blink_phase=1 and its value otherwise; digits 0, 2 and 3 are unaffected; without the macro, digit 1 is never blanked.
REQ-034 SHALL cover: rst_n pulled low for 1 cycle mid-S_SHOW on digit 2 -> outputs go immediately to reset values, and the next frame_start occurs 4 cycles after release.
REQ-035 SHALL cover: d3=4'hC -> digit_val=4'hC in S_SHOW of digit 3, and 4'hF in every S_BLANK slot.
REQ-036 SHALL cover: TICK_DIV=1 -> a tick every cycle and a frame period of 16 cycles.
